trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16 (power of two, 2..256), giving FIFO depth in records.
REQ-002 The block SHALL have parameter DROP_W, default 16, giving the drop-counter width.
REQ-003 The block SHALL have port clk_in, input, 1 bit, the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port cap_en, input, 1 bit, enabling capture of one retired instruction per cycle.
REQ-006 The block SHALL have port pc, input, 32 bits, the PC of the retiring instruction.
REQ-007 The block SHALL have port inst, input, 32 bits, the retiring instruction word.
REQ-008 The block SHALL have ports rf_we (1 bit), rf_waddr (5 bits) and rf_wdata (32 bits), all inputs, carrying the register-file write of that instruction.
REQ-009 The block SHALL have port m_valid, output, 1 bit, indicating that a trace word is available.
REQ-010 The block SHALL have port m_ready, input, 1 bit, the consumer's acceptance.
REQ-011 The block SHALL have ports m_data (output, 32 bits, the trace word) and m_last (output, 1 bit, marking the final word of a record).
REQ-012 The block SHALL have ports level (output, log2(DEPTH)+1 bits, FIFO occupancy) and drop_cnt (output, DROP_W bits, count of lost records).

Function
REQ-013 The block SHALL, on each rising clk_in edge with cap_en=1 (subject to REQ-026), form a record {pc, inst, rf_we, rf_waddr, rf_wdata} and push it to the FIFO.
REQ-014 The block SHALL, when a push is attempted while the FIFO is full and no record is being retired that cycle, discard the record and increment drop_cnt, saturating at all-ones.
REQ-015 The block SHALL serialize the head record as four words: W0=pc; W1=inst; W2={rf_we, 26'b0, rf_waddr}; W3=rf_wdata.
REQ-016 The serializer state machine SHALL have states IDLE, W0, W1, W2 and W3.
REQ-017 From IDLE, the state machine SHALL move to W0 when level is greater than 0.
REQ-018 In each state Wn, the state machine SHALL advance to Wn+1 only on m_valid && m_ready.
REQ-019 From W3, on acceptance, the state machine SHALL pop the record, then go to W0 if another record remains and to IDLE otherwise.
REQ-020 m_valid SHALL be 1 exactly in states W0..W3, and m_data and m_last SHALL be stable while m_valid=1 && m_ready=0.
REQ-021 m_last SHALL be 1 only in state W3.
REQ-022 Latency: a record pushed at edge N into an empty FIFO SHALL present W0 with m_valid=1 no earlier than edge N+1 and no later than edge N+2; there SHALL be no combinational path from cap_en or any capture input to m_valid or m_data.
REQ-023 When the FIFO is full and a W3 acceptance coincides with a push, the block SHALL accept the push, leaving level unchanged and drop_cnt unchanged.
REQ-024 The read and write pointers SHALL wrap modulo DEPTH; level SHALL equal pushes minus pops, in the range 0..DEPTH.
REQ-025 Back-to-back records SHALL stream with no idle cycle between a W3 acceptance and the next W0.

Reset
REQ-026 reset=0 SHALL immediately, without waiting for a clock edge, clear the pointers, level, drop_cnt, m_valid, m_last and m_data to 0 and force the state machine to IDLE; this SHALL apply mid-record as well, and the partial record SHALL be lost.
REQ-027 The block SHALL perform no capture while reset=0, and the first capture SHALL occur on the first rising edge after reset deasserts.
REQ-028 FIFO storage contents SHALL NOT be required to be reset.

Configuration
REQ-029 When macro TRACE_WB_FILTER_EN is defined, the block SHALL push a record only when cap_en=1 && rf_we=1 && rf_waddr!=0.
REQ-030 When macro TRACE_WB_FILTER_EN is undefined, the block SHALL push a record on every cycle with cap_en=1.
REQ-031 Apart from the push condition, the interface and all other behaviour SHALL be identical with and without TRACE_WB_FILTER_EN.

Verification
REQ-032 Single record, with m_ready held at 1: push pc=0x00400000, inst=0x24010005, rf_we=1, rf_waddr=1, rf_wdata=5 -> m_data SHALL be 0x00400000, 0x24010005, 0x80000001, 0x00000005 on consecutive cycles, with m_last=1 only on the 4th word.
REQ-033 Overflow, with DEPTH=16 and m_ready=0: push 20 records -> level SHALL be 16 and drop_cnt SHALL be 4; draining SHALL yield the first 16 records in order.
REQ-034 Backpressure: toggle m_ready randomly during 3 records -> each word SHALL be held stable until accepted, and there SHALL be exactly 12 handshakes with m_last on handshakes 4, 8 and 12.
REQ-035 Full with simultaneous pop: FIFO full, then W3 accepted in the same cycle as a push -> level SHALL stay 16 and drop_cnt SHALL stay unchanged.
REQ-036 Reset mid-record: assert reset=0 in state W1 -> m_valid, level and drop_cnt SHALL be 0 before the next edge, and after release the FIFO SHALL be empty.
REQ-037 With TRACE_WB_FILTER_EN defined: push a sw (rf_we=0) and an addi to $0 -> level SHALL stay 0; push an addi to $2 -> level SHALL be 1.

Source files
------------

// File: rtl/trace_capture.sv
// Retired-instruction trace capture: records are queued in a FIFO and streamed out as four 32-bit words each.
// Optional macro TRACE_WB_FILTER_EN restricts capture to instructions that write a nonzero register.

module trace_capture #(
  parameter  int DEPTH  = 16,
  parameter  int DROP_W = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int LVL_W  = AW + 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [31:0]       rf_wdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic [LVL_W-1:0]  level,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rec_t;

  typedef enum logic [2:0] {IDLE, W0, W1, W2, W3} state_t;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  rec_t               mem_q [DEPTH];
  rec_t               rec_in;
  rec_t               head;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  state_t             state_q, state_d;

  logic push_req;
  logic full;
  logic pop;
  logic push_ok;
  logic drop;

  assign rec_in = '{pc: pc, inst: inst, rf_we: rf_we, rf_waddr: rf_waddr, rf_wdata: rf_wdata};

`ifdef TRACE_WB_FILTER_EN
  assign push_req = cap_en && rf_we && (rf_waddr != 5'd0);
`else
  assign push_req = cap_en;
`endif

  // A full FIFO still takes a record when the head record leaves on the same edge.
  assign full    = (level_q == FULL_LVL);
  assign pop     = (state_q == W3) && m_ready;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  // NOTE: every variable gets a default at the top of an always_comb, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);

    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Serializer: each word is held until accepted; W3 acceptance retires the head record.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (level_q != '0) state_d = W0;
      W0:   if (m_ready) state_d = W1;
      W1:   if (m_ready) state_d = W2;
      W2:   if (m_ready) state_d = W3;
      W3:   if (m_ready) state_d = (level_d != '0) ? W0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

  // NOTE: record storage has no reset; pointers and level alone decide which entries are meaningful.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Outputs depend only on registered state and stored records, never on the capture inputs.
  always_comb begin
    m_data = '0;
    unique case (state_q)
      W0:      m_data = head.pc;
      W1:      m_data = head.inst;
      W2:      m_data = {head.rf_we, 26'b0, head.rf_waddr};
      W3:      m_data = head.rf_wdata;
      default: m_data = '0;
    endcase
  end

  assign m_valid  = (state_q != IDLE);
  assign m_last   = (state_q == W3);
  assign level    = level_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: a record-level queue model predicts the word stream, level and drop count.
// Honours TRACE_WB_FILTER_EN in the model and adds the filter scenario when it is defined.

module tb_trace_capture;

  localparam int DEPTH    = 16;
  localparam int DROP_W   = 16;
  localparam int LVL_W    = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk_in = 1'b0;
  logic              reset = 1'b1;
  logic              cap_en = 1'b0;
  logic [31:0]       pc = '0;
  logic [31:0]       inst = '0;
  logic              rf_we = 1'b0;
  logic [4:0]        rf_waddr = '0;
  logic [31:0]       rf_wdata = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [31:0]       m_data;
  logic              m_last;
  logic [LVL_W-1:0]  level;
  logic [DROP_W-1:0] drop_cnt;

  trace_capture #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .cap_en   (cap_en),
    .pc       (pc),
    .inst     (inst),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          idx;
  } word_t;

  word_t       sb[$];
  int          last_at[$];
  logic [31:0] hs_log[$];
  int          m_level = 0;
  int          m_drop = 0;
  int          coinc_cnt = 0;
  int          hs_cnt = 0;
  int          wait_cnt = 0;
  bit          expect_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input logic [31:0] d, input int i);
    word_t w;
    w.data = d;
    w.last = (i == 3);
    w.idx  = i;
    sb.push_back(w);
  endtask

  // Reference model: a record either enters the queue (four expected words) or is counted as dropped.
  always @(negedge clk_in) begin : model
    bit pop_ev;
    bit req;
    if (reset) begin
      check("level", 64'(level), 64'(m_level));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      pop_ev = m_valid && m_ready && m_last;
`ifdef TRACE_WB_FILTER_EN
      req = cap_en && rf_we && (rf_waddr != 5'd0);
`else
      req = cap_en;
`endif
      if (req) begin
        if (m_level < DEPTH || pop_ev) begin
          if (m_level == DEPTH) coinc_cnt++;
          sb_push(pc, 0);
          sb_push(inst, 1);
          sb_push({rf_we, 26'b0, rf_waddr}, 2);
          sb_push(rf_wdata, 3);
          m_level++;
        end else if (m_drop < DROP_MAX) begin
          m_drop++;
        end
      end
      if (pop_ev) m_level--;
    end
  end

  // Monitor: compares every presented word against the scoreboard head, pops on handshake.
  always @(negedge clk_in) begin : monitor
    bit was_last;
    #1;
    if (reset) begin
      if (expect_valid) begin
        check("stream_gap_m_valid", 64'(m_valid), 64'd1);
        expect_valid = 1'b0;
      end
      if (m_valid) begin
        wait_cnt = 0;
        if (sb.size() == 0) begin
          check("unexpected_m_valid", 64'(m_valid), 64'd0);
        end else begin
          check("m_data", 64'(m_data), 64'(sb[0].data));
          check("m_last", 64'(m_last), 64'(sb[0].last));
          if (m_ready) begin
            was_last = sb[0].last;
            hs_cnt++;
            hs_log.push_back(m_data);
            if (m_last) last_at.push_back(hs_cnt);
            void'(sb.pop_front());
            if (was_last && sb.size() != 0) expect_valid = 1'b1;
          end
        end
      end else begin
        check("m_last_without_valid", 64'(m_last), 64'd0);
        if (sb.size() != 0) begin
          wait_cnt++;
          if (wait_cnt > 3) begin
            check("w0_latency_cycles", 64'(wait_cnt), 64'd3);
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_rand_rec(input bit en);
    cap_en   = en;
    pc       = $urandom;
    inst     = $urandom;
    rf_we    = 1'($urandom);
    rf_waddr = 5'($urandom);
    rf_wdata = $urandom;
  endtask

  // A record that passes the write-back filter, so directed counts hold in both builds.
  task automatic set_valid_rec();
    set_rand_rec(1'b1);
    rf_we    = 1'b1;
    rf_waddr = 5'($urandom_range(1, 31));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    cap_en  = 1'b0;
    m_ready = 1'b1;
    while ((sb.size() != 0 || m_valid) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_complete", 64'(sb.size()), 64'd0);
  endtask

  task automatic apply_reset_mid();
    @(negedge clk_in);
    #3;
    reset = 1'b0;
    #1;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    sb.delete();
    m_level      = 0;
    m_drop       = 0;
    expect_valid = 1'b0;
    wait_cnt     = 0;
    set_valid_rec();
    @(posedge clk_in);
    #1;
    check("no_capture_in_reset", 64'(level), 64'd0);
    reset  = 1'b1;
    cap_en = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c0;
    int n;
    int ready_pct[4];
    ready_pct[0] = 20;
    ready_pct[1] = 60;
    ready_pct[2] = 95;
    ready_pct[3] = 45;

    #2 reset = 1'b0;
    #1;
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_m_last", 64'(m_last), 64'd0);
    check("reset_m_data", 64'(m_data), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b1;

    // Single record with the consumer always ready.
    hs_log.delete();
    last_at.delete();
    hs_cnt   = 0;
    m_ready  = 1'b1;
    cap_en   = 1'b1;
    pc       = 32'h0040_0000;
    inst     = 32'h2401_0005;
    rf_we    = 1'b1;
    rf_waddr = 5'd1;
    rf_wdata = 32'h0000_0005;
    cycle();
    cap_en = 1'b0;
    drain(20);
    check("single_hs_count", 64'(hs_log.size()), 64'd4);
    if (hs_log.size() == 4) begin
      check("single_w0", 64'(hs_log[0]), 64'h0040_0000);
      check("single_w1", 64'(hs_log[1]), 64'h2401_0005);
      check("single_w2", 64'(hs_log[2]), 64'h8000_0001);
      check("single_w3", 64'(hs_log[3]), 64'h0000_0005);
    end
    check("single_last_count", 64'(last_at.size()), 64'd1);
    if (last_at.size() == 1) check("single_last_pos", 64'(last_at[0]), 64'd4);

    // Overflow: 20 records into a stalled 16-deep FIFO.
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_valid_rec();
      cycle();
    end
    cap_en = 1'b0;
    check("overflow_level", 64'(level), 64'd16);
    check("overflow_drop_cnt", 64'(drop_cnt), 64'd4);
    hs_cnt = 0;
    drain(200);
    check("overflow_drain_words", 64'(hs_cnt), 64'd64);

    // Full FIFO while pushing every cycle: W3 acceptances coincide with pushes.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_valid_rec();
      cycle();
    end
    m_ready = 1'b1;
    c0 = coinc_cnt;
    for (int i = 0; i < 24; i++) begin
      set_valid_rec();
      cycle();
    end
    cap_en = 1'b0;
    check("full_pop_level", 64'(level), 64'd16);
    check("full_pop_coincidence_seen", 64'(coinc_cnt > c0), 64'd1);

    // Reset while the head record sits in W1.
    n = 0;
    while (!(m_valid && sb.size() != 0 && sb[0].idx == 1) && n < 20) begin
      cycle();
      n++;
    end
    m_ready = 1'b0;
    check("reached_w1", 64'(m_valid && sb.size() != 0 && sb[0].idx == 1), 64'd1);
    apply_reset_mid();
    repeat (2) cycle();
    check("post_reset_level", 64'(level), 64'd0);
    check("post_reset_m_valid", 64'(m_valid), 64'd0);

    // Backpressure: three records under a random ready pattern.
    hs_cnt = 0;
    last_at.delete();
    for (int i = 0; i < 3; i++) begin
      set_valid_rec();
      m_ready = 1'($urandom);
      cycle();
    end
    cap_en = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      m_ready = 1'($urandom);
      cycle();
      n++;
    end
    m_ready = 1'b1;
    cycle();
    check("bp_handshakes", 64'(hs_cnt), 64'd12);
    check("bp_last_count", 64'(last_at.size()), 64'd3);
    if (last_at.size() == 3) begin
      check("bp_last_1", 64'(last_at[0]), 64'd4);
      check("bp_last_2", 64'(last_at[1]), 64'd8);
      check("bp_last_3", 64'(last_at[2]), 64'd12);
    end

`ifdef TRACE_WB_FILTER_EN
    // Stores and writes to $0 are filtered; a write to $2 is captured.
    drain(50);
    m_ready  = 1'b0;
    set_rand_rec(1'b1);
    rf_we    = 1'b0;
    rf_waddr = 5'd5;
    cycle();
    set_rand_rec(1'b1);
    rf_we    = 1'b1;
    rf_waddr = 5'd0;
    cycle();
    cap_en = 1'b0;
    check("filter_level_zero", 64'(level), 64'd0);
    set_rand_rec(1'b1);
    rf_we    = 1'b1;
    rf_waddr = 5'd2;
    cycle();
    cap_en = 1'b0;
    check("filter_level_one", 64'(level), 64'd1);
    drain(50);
`endif

    // Randomized traffic across several consumer ready rates.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 500; i++) begin
        set_rand_rec($urandom_range(0, 99) < 70);
        m_ready = ($urandom_range(0, 99) < ready_pct[b]);
        cycle();
      end
    end
    drain(400);
    check("final_level", 64'(level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
